// File: rtl/handler_tx_arbiter.sv
// Round-robin merge of per-kernel AXI streams into one handler stream; each packet is a header beat then payload.
// Optional packet counter output enabled by defining HANDLER_TX_STATS_EN.
module handler_tx_arbiter #(
    parameter int NUM_KERNELS = 2,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [NUM_KERNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_KERNELS-1:0]            s_axis_tvalid,
    input  logic [NUM_KERNELS-1:0]            s_axis_tlast,
    output logic [NUM_KERNELS-1:0]            s_axis_tready,
    input  logic [NUM_KERNELS*4-1:0]          s_amhandler,
    input  logic [15:0]                       address_offset,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready
`ifdef HANDLER_TX_STATS_EN
    ,
    output logic [31:0]                       pkt_count
`endif
);

    localparam int IDX_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [IDX_W-1:0]       grant_q;
    logic [3:0]             handler_q;

    logic [IDX_W-1:0]       grant_d;
    logic                   req_found_s;
    logic [NUM_KERNELS-1:0] rot_valid_s;
    logic [3:0]             req_handler_s;
    logic [DATA_WIDTH-1:0]  g_data_s;
    logic                   g_valid_s;
    logic                   g_last_s;
    logic [15:0]            hdr_addr_s;
    logic                   pkt_done_s;

    // Round-robin search: rotate requests so rr_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        int cand;
        cand        = 0;
        grant_d     = rr_ptr_q;
        req_found_s = 1'b0;
        rot_valid_s = NUM_KERNELS'({s_axis_tvalid, s_axis_tvalid} >> rr_ptr_q);
        for (int i = 0; i < NUM_KERNELS; i++) begin
            if (!req_found_s && rot_valid_s[i]) begin
                req_found_s = 1'b1;
                cand        = int'(rr_ptr_q) + i;
                if (cand >= NUM_KERNELS) begin
                    cand = cand - NUM_KERNELS;
                end else begin
                    cand = cand;
                end
                grant_d = IDX_W'(cand);
            end else begin
                grant_d = grant_d;
            end
        end
    end

    // Per-kernel muxes: handler of the candidate winner, stream signals of the current grant.
    always_comb begin
        req_handler_s = 4'd0;
        g_data_s      = '0;
        g_valid_s     = 1'b0;
        g_last_s      = 1'b0;
        for (int k = 0; k < NUM_KERNELS; k++) begin
            if (grant_d == IDX_W'(k)) begin
                req_handler_s = s_amhandler[k*4 +: 4];
            end else begin
                req_handler_s = req_handler_s;
            end
            if (grant_q == IDX_W'(k)) begin
                g_data_s  = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                g_valid_s = s_axis_tvalid[k];
                g_last_s  = s_axis_tlast[k];
            end else begin
                g_data_s  = g_data_s;
            end
        end
    end

    assign hdr_addr_s = address_offset + 16'(grant_q);
    assign pkt_done_s = (state_q == ST_PAYLOAD) && g_valid_s && m_axis_tready && g_last_s;

    // Output steering: header is built from latched fields, payload passes straight through.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        case (state_q)
            ST_HEADER: begin
                m_axis_tdata[55:52] = handler_q;
                m_axis_tdata[39:24] = hdr_addr_s;
                m_axis_tvalid       = 1'b1;
            end
            ST_PAYLOAD: begin
                m_axis_tdata  = g_data_s;
                m_axis_tvalid = g_valid_s;
                m_axis_tlast  = g_last_s;
                for (int k = 0; k < NUM_KERNELS; k++) begin
                    if (grant_q == IDX_W'(k)) begin
                        s_axis_tready[k] = m_axis_tready;
                    end else begin
                        s_axis_tready[k] = 1'b0;
                    end
                end
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

    // Packet FSM; the grant and handler are captured once so later input changes cannot alter the header.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            handler_q <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_found_s) begin
                        grant_q   <= grant_d;
                        handler_q <= req_handler_s;
                        state_q   <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (m_axis_tready) begin
                        state_q <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (pkt_done_s) begin
                        state_q  <= ST_IDLE;
                        rr_ptr_q <= (grant_q == IDX_W'(NUM_KERNELS - 1)) ? '0 : grant_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef HANDLER_TX_STATS_EN
    logic [31:0] pkt_count_q;

    // Completed-packet counter, wraps naturally at 2^32.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count_q <= 32'd0;
        end else if (pkt_done_s) begin
            pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_handler_tx_arbiter.sv
// Randomized bench for handler_tx_arbiter with a packet-level round-robin reference model.
module tb_handler_tx_arbiter;
    localparam int N = 3;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [N*64-1:0] s_axis_tdata = '0;
    logic [N-1:0]    s_axis_tvalid = '0;
    logic [N-1:0]    s_axis_tlast = '0;
    logic [N-1:0]    s_axis_tready;
    logic [N*4-1:0]  s_amhandler = '0;
    logic [15:0]     address_offset = 16'h0010;
    logic [63:0]     m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready = 1'b0;
`ifdef HANDLER_TX_STATS_EN
    logic [31:0]     pkt_count;
`endif

    handler_tx_arbiter #(.NUM_KERNELS(N), .DATA_WIDTH(64)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .s_amhandler    (s_amhandler),
        .address_offset (address_offset),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready)
`ifdef HANDLER_TX_STATS_EN
        ,
        .pkt_count      (pkt_count)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Source-side packet stores, one per kernel.
    logic [63:0] pk_data [N][8];
    int          pk_len  [N];
    int          pk_pos  [N];
    bit          has_pkt [N];
    bit          gate    [N];
    logic [3:0]  hnd     [N];
    int          pk_seq  [N];

    // Reference model state.
    bit          busy;
    bit          hdr_pend;
    int          g;
    int          rr;
    int          pkts;
    logic [63:0] hdr_w;
    logic [64:0] expq[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            s_axis_tvalid[k]      = has_pkt[k] && gate[k];
            s_axis_tdata[k*64 +: 64] = has_pkt[k] ? pk_data[k][pk_pos[k]] : 64'd0;
            s_axis_tlast[k]       = has_pkt[k] && (pk_pos[k] == pk_len[k] - 1);
            s_amhandler[k*4 +: 4] = hnd[k];
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) begin
            has_pkt[k] = 1'b0;
            pk_pos[k]  = 0;
            pk_len[k]  = 0;
            gate[k]    = 1'b0;
            hnd[k]     = 4'd0;
        end
        busy     = 1'b0;
        hdr_pend = 1'b0;
        g        = 0;
        rr       = 0;
        pkts     = 0;
        expq.delete();
    endtask

    task automatic step();
        bit          was_busy;
        logic [N-1:0] fire;
        logic [64:0] beat;
        bit          found;
        @(negedge clock);
        was_busy = busy;
        fire     = s_axis_tvalid & s_axis_tready;
        if (!busy) begin
            check_eq("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
            check_eq("idle_sready", 64'(s_axis_tready), 64'd0);
        end else begin
            check_eq("tvalid", 64'(m_axis_tvalid), hdr_pend ? 64'd1 : 64'(s_axis_tvalid[g]));
            check_eq("sready", 64'(s_axis_tready),
                     hdr_pend ? 64'd0 : (64'(m_axis_tready) << g));
            if (hdr_pend) begin
                check_eq("hdr_data", m_axis_tdata, hdr_w);
                check_eq("hdr_last", 64'(m_axis_tlast), 64'd0);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (expq.size() == 0) begin
                    check_eq("extra_beat", 64'd1, 64'd0);
                end else begin
                    beat = expq.pop_front();
                    check_eq("beat_data", m_axis_tdata, beat[63:0]);
                    check_eq("beat_last", 64'(m_axis_tlast), 64'(beat[64]));
                    hdr_pend = 1'b0;
                    if (beat[64]) begin
                        busy = 1'b0;
                        rr   = (g + 1) % N;
                        pkts++;
                    end
                end
            end
        end
        if (!was_busy) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!found && s_axis_tvalid[(rr + i) % N]) begin
                    found = 1'b1;
                    g     = (rr + i) % N;
                end
            end
            if (found) begin
                busy        = 1'b1;
                hdr_pend    = 1'b1;
                hdr_w       = 64'd0;
                hdr_w[55:52] = hnd[g];
                hdr_w[39:24] = 16'((g + int'(address_offset)) % 65536);
                expq.push_back({1'b0, hdr_w});
                for (int i = pk_pos[g]; i < pk_len[g]; i++) begin
                    expq.push_back({(i == pk_len[g] - 1) ? 1'b1 : 1'b0, pk_data[g][i]});
                end
            end
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < N; k++) begin
            if (fire[k]) begin
                pk_pos[k]++;
                if (pk_pos[k] >= pk_len[k]) has_pkt[k] = 1'b0;
            end
            if (!has_pkt[k] && $urandom_range(0, 3) == 0) begin
                has_pkt[k] = 1'b1;
                pk_pos[k]  = 0;
                pk_len[k]  = int'($urandom_range(1, 4));
                pk_seq[k]++;
                for (int i = 0; i < 8; i++) begin
                    pk_data[k][i] = {8'(k), 8'(pk_seq[k]), 8'(i), 8'($urandom), 32'($urandom)};
                end
            end
            gate[k] = ($urandom_range(0, 9) < 8);
            hnd[k]  = 4'($urandom);
        end
        m_axis_tready = ($urandom_range(0, 9) < 7);
        drive_inputs();
    endtask

    task automatic do_reset(input logic [15:0] off);
        reset_n = 1'b0;
        #1;
        check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check_eq("rst_sready", 64'(s_axis_tready), 64'd0);
`ifdef HANDLER_TX_STATS_EN
        check_eq("rst_pkt_count", 64'(pkt_count), 64'd0);
`endif
        clear_all();
        address_offset = off;
        m_axis_tready  = 1'b1;
        drive_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] offs [4];
        offs[0] = 16'h0010;
        offs[1] = 16'hFFFF;
        offs[2] = 16'hFFFE;
        offs[3] = 16'($urandom);
        for (int k = 0; k < N; k++) pk_seq[k] = 0;
        clear_all();
        drive_inputs();
        #2;
        for (int r = 0; r < 4; r++) begin
            do_reset(offs[r]);
            for (int c = 0; c < 600; c++) step();
            check_eq("progress", 64'(pkts > 20), 64'd1);
`ifdef HANDLER_TX_STATS_EN
            check_eq("pkt_count", 64'(pkt_count), 64'(pkts));
`endif
            // Leave the run mid-packet where possible so the next reset abandons it.
            for (int c = 0; c < 40 && !(busy && !hdr_pend); c++) step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/handler_tx_arbiter.md
HANDLER_TX_ARBITER -- requirements
Module: handler_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_KERNELS, default 2, number of kernel sources (legal 1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, stream data width (fixed at 64).
REQ-003 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port s_axis_tdata, input, NUM_KERNELS*64, payload data; kernel k occupies bits [64k+63:64k].
REQ-006 SHALL have ports s_axis_tvalid / s_axis_tlast, input, NUM_KERNELS each, per-kernel valid and last.
REQ-007 SHALL have port s_axis_tready, output, NUM_KERNELS, per-kernel ready.
REQ-008 SHALL have port s_amhandler, input, NUM_KERNELS*4, per-kernel AM handler ID; kernel k occupies bits [4k+3:4k].
REQ-009 SHALL have port address_offset, input, 16, base address of this node's kernels.
REQ-010 SHALL have ports m_axis_tdata (output, 64), m_axis_tvalid (output, 1), m_axis_tlast (output, 1), m_axis_tready (input, 1), merged handler stream.

Function
REQ-011 SHALL implement states ST_IDLE, ST_HEADER and ST_PAYLOAD.
REQ-012 In ST_IDLE, SHALL grant the first kernel with s_axis_tvalid high, searching upward from rr_ptr modulo NUM_KERNELS, and move to ST_HEADER on the next edge.
REQ-013 On grant, SHALL latch grant index and that kernel's s_amhandler; later changes to s_amhandler SHALL NOT affect the packet.
REQ-014 ST_HEADER: m_axis_tvalid=1, m_axis_tlast=0, m_axis_tdata[55:52]=latched handler, [39:24]=(grant+address_offset) mod 2^16, all other bits 0.
REQ-015 ST_HEADER: all s_axis_tready SHALL be 0; header held stable until m_axis_tready=1, then move to ST_PAYLOAD.
REQ-016 ST_PAYLOAD: m_axis_tdata/tvalid/tlast SHALL combinationally follow the granted kernel; s_axis_tready[grant]=m_axis_tready; all other s_axis_tready SHALL be 0.
REQ-017 ST_PAYLOAD: on m_axis_tvalid & m_axis_tready & m_axis_tlast, SHALL return to ST_IDLE and set rr_ptr=(grant+1) mod NUM_KERNELS.
REQ-018 Granted-source tvalid deasserting mid-packet SHALL stall without state change.
REQ-019 In ST_IDLE, m_axis_tvalid and all s_axis_tready SHALL be 0; minimum idle gap between packets SHALL be one cycle.
REQ-020 A lone requester SHALL be re-granted after its own packet; no kernel SHALL wait more than NUM_KERNELS-1 packets.
REQ-021 Every packet SHALL carry at least one payload beat; the header is never marked last.

Reset
REQ-022 reset_n low SHALL asynchronously force ST_IDLE, rr_ptr=0, grant=0, latched handler=0, m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0.
REQ-023 Reset mid-packet SHALL abandon the packet; no further beats of it are forwarded after release.

Configuration
REQ-024 With HANDLER_TX_STATS_EN defined, SHALL add output pkt_count (32 bits), reset 0, incremented on each output tlast handshake, wrapping 0xFFFFFFFF->0.
REQ-025 Without HANDLER_TX_STATS_EN, port pkt_count and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-026 NUM_KERNELS=2, address_offset=0x0010, kernel 1 sends handler 0x3 and 2 beats (A,B), m_axis_tready=1 -> header with [39:24]=0x0011, [55:52]=0x3, then A, B(last); 3 output beats.
REQ-027 Kernels 0 and 1 both valid from reset -> order k0, k1, k0, k1; rr_ptr alternates.
REQ-028 m_axis_tready low 5 cycles during ST_HEADER -> header stable, s_axis_tready all 0, no payload consumed.
REQ-029 address_offset=0xFFFF, grant kernel 1 -> header [39:24]=0x0000.
REQ-030 reset_n pulsed low after first payload beat of a 4-beat packet -> outputs immediately 0, ST_IDLE; next packet begins with header. With HANDLER_TX_STATS_EN: 3 complete packets -> pkt_count=3.
